// File: rtl/mips_bus_pkg.sv
// Shared types and widths for the instruction/data memory bus arbiter.
// Grant ids double as the encoding of the last_grant register.
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_rr_select.sv
// Two-way round-robin winner pick: on a tie the port not granted last wins.
module bus_rr_select
    import mips_bus_pkg::*;
(
    input  logic if_pending,
    input  logic d_pending,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = if_pending | d_pending;
        grant_id    = GNT_IF;
        if (if_pending && d_pending) begin
            grant_id = ~last_grant;
        end else if (d_pending) begin
            grant_id = GNT_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus.
// Only the grant state and last_grant are stored; all data paths are muxes.
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] if_address,
    input  logic              if_read,
    output logic [DATA_W-1:0] if_readdata,
    output logic              if_waitrequest,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_waitrequest,

    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       if_pending, d_pending;
    logic       grant_valid, grant_id;

    assign if_pending = if_read;
    assign d_pending  = d_read | d_write;

    bus_rr_select u_rr (
        .if_pending  (if_pending),
        .d_pending   (d_pending),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = grant_id ? GRANT_D : GRANT_IF;
                end
            end
            GRANT_IF: begin
                if (!if_pending) begin
                    state_d = IDLE;
                end else if (!waitrequest && d_pending) begin
                    state_d = GRANT_D;
                end
            end
            GRANT_D: begin
                if (!d_pending) begin
                    state_d = IDLE;
                end else if (!waitrequest && if_pending) begin
                    state_d = GRANT_IF;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GRANT_IF) begin
            last_grant_d = GNT_IF;
        end else if (state_d == GRANT_D) begin
            last_grant_d = GNT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ~DATA_FIRST;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign if_readdata = readdata;
    assign d_readdata  = readdata;

    // A cycle with reset high never reports completion to the owner.
    always_comb begin
        address        = '0;
        read           = 1'b0;
        write          = 1'b0;
        writedata      = '0;
        byteenable     = '0;
        if_waitrequest = 1'b1;
        d_waitrequest  = 1'b1;
        unique case (state_q)
            IDLE: begin
            end
            GRANT_IF: begin
                address        = if_address;
                read           = if_read;
                byteenable     = '1;
                if_waitrequest = waitrequest | reset;
            end
            GRANT_D: begin
                address        = d_address;
                read           = d_read & ~d_write;
                write          = d_write;
                writedata      = d_writedata;
                byteenable     = d_byteenable;
                d_waitrequest  = waitrequest | reset;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: driver predicts each cycle's outputs from an ownership
// model, a negedge monitor pops and compares them against the arbiter.
module tb_mem_bus_arbiter;
    import mips_bus_pkg::*;

    localparam bit DF = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_address;
    logic        if_read;
    logic [31:0] if_readdata;
    logic        if_waitrequest;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DATA_FIRST(DF)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_address     (if_address),
        .if_read        (if_read),
        .if_readdata    (if_readdata),
        .if_waitrequest (if_waitrequest),
        .d_address      (d_address),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_writedata    (d_writedata),
        .d_byteenable   (d_byteenable),
        .d_readdata     (d_readdata),
        .d_waitrequest  (d_waitrequest),
        .address        (address),
        .read           (read),
        .write          (write),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .readdata       (readdata),
        .waitrequest    (waitrequest)
    );

    typedef struct {
        logic        rst;
        logic [31:0] if_addr;
        logic        if_rd;
        logic [31:0] d_addr;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] d_wd;
        logic [3:0]  d_be;
        logic [31:0] rdata;
        logic        wr;
    } stim_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
        logic [31:0] if_readdata;
        logic        if_waitrequest;
        logic [31:0] d_readdata;
        logic        d_waitrequest;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: who owns the bus (0 none, 1 instruction, 2 data) and
    // which port should win the next tie.
    int   owner;
    bit   prefer_d;

    function automatic stim_t base();
        stim_t s;
        s.rst     = 1'b0;
        s.if_addr = 32'h0;
        s.if_rd   = 1'b0;
        s.d_addr  = 32'h0;
        s.d_rd    = 1'b0;
        s.d_wr    = 1'b0;
        s.d_wd    = 32'h0;
        s.d_be    = 4'h0;
        s.rdata   = $urandom;
        s.wr      = 1'b0;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.address        = address;
        a.read           = read;
        a.write          = write;
        a.writedata      = writedata;
        a.byteenable     = byteenable;
        a.if_readdata    = if_readdata;
        a.if_waitrequest = if_waitrequest;
        a.d_readdata     = d_readdata;
        a.d_waitrequest  = d_waitrequest;
        return a;
    endfunction

    task automatic step(input stim_t s, input string tag);
        obs_t e;
        exp_t x;
        bit   if_p;
        bit   d_p;
        @(posedge clk);
        #1;
        reset        = s.rst;
        if_address   = s.if_addr;
        if_read      = s.if_rd;
        d_address    = s.d_addr;
        d_read       = s.d_rd;
        d_write      = s.d_wr;
        d_writedata  = s.d_wd;
        d_byteenable = s.d_be;
        readdata     = s.rdata;
        waitrequest  = s.wr;

        e = '0;
        e.if_readdata    = s.rdata;
        e.d_readdata     = s.rdata;
        e.if_waitrequest = 1'b1;
        e.d_waitrequest  = 1'b1;
        if (owner == 1) begin
            e.address        = s.if_addr;
            e.read           = s.if_rd;
            e.byteenable     = 4'hF;
            e.if_waitrequest = s.rst | s.wr;
        end else if (owner == 2) begin
            e.address       = s.d_addr;
            e.write         = s.d_wr;
            e.read          = s.d_rd & ~s.d_wr;
            e.writedata     = s.d_wd;
            e.byteenable    = s.d_be;
            e.d_waitrequest = s.rst | s.wr;
        end
        x.o   = e;
        x.tag = tag;
        exp_q.push_back(x);

        if_p = s.if_rd;
        d_p  = s.d_rd | s.d_wr;
        if (s.rst) begin
            owner    = 0;
            prefer_d = DF;
        end else begin
            if (owner == 0) begin
                if (if_p && d_p) owner = prefer_d ? 2 : 1;
                else if (if_p)   owner = 1;
                else if (d_p)    owner = 2;
            end else if (owner == 1) begin
                if (!if_p)             owner = 0;
                else if (!s.wr && d_p) owner = 2;
            end else begin
                if (!d_p)               owner = 0;
                else if (!s.wr && if_p) owner = 1;
            end
            if (owner != 0) prefer_d = (owner == 1);
        end
    endtask

    initial begin : monitor
        exp_t x;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                a = sample();
                checks++;
                if (a !== x.o) begin
                    errors++;
                    $display("FAIL %s t=%0t got=%h exp=%h",
                             x.tag, $time, a, x.o);
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        reset        = 1'b1;
        if_address   = 32'h0;
        if_read      = 1'b0;
        d_address    = 32'h0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        d_writedata  = 32'h0;
        d_byteenable = 4'h0;
        readdata     = 32'h0;
        waitrequest  = 1'b0;
        owner        = 0;
        prefer_d     = DF;
        repeat (2) @(posedge clk);

        s = base(); s.rst = 1'b1; s.if_rd = 1'b1; s.d_wr = 1'b1;
        step(s, "reset_state");

        for (int i = 0; i < 3; i++) begin
            s = base();
            s.if_rd   = (i < 2);
            s.if_addr = 32'hBFC00000;
            step(s, "if_fetch");
        end

        for (int i = 0; i < 7; i++) begin
            s = base();
            s.if_rd   = 1'b1;
            s.if_addr = 32'h00400000 + 32'(i * 4);
            s.d_rd    = 1'b1;
            s.d_addr  = 32'h10010000 + 32'(i * 4);
            s.d_be    = 4'hF;
            step(s, "both_alternate");
        end
        s = base();
        step(s, "both_release");

        for (int i = 0; i < 5; i++) begin
            s = base();
            s.d_wr   = (i < 4);
            s.d_addr = 32'h00001004;
            s.d_wd   = 32'hDEADBEEF;
            s.d_be   = 4'b0011;
            s.wr     = (i < 3);
            step(s, "d_write_wait");
        end

        for (int i = 0; i < 3; i++) begin
            s = base();
            s.d_rd   = (i < 2);
            s.d_wr   = (i < 2);
            s.d_addr = 32'h00002000;
            s.d_wd   = 32'h12345678;
            s.d_be   = 4'hC;
            step(s, "d_rd_wr_both");
        end

        for (int i = 0; i < 4; i++) begin
            s = base();
            s.rst    = (i == 2);
            s.d_wr   = 1'b1;
            s.d_addr = 32'h00003000;
            s.d_wd   = 32'hA5A5A5A5;
            s.d_be   = 4'hF;
            s.wr     = 1'b1;
            step(s, "reset_mid_d");
        end
        s = base();
        step(s, "reset_release");

        for (int i = 0; i < 4; i++) begin
            s = base();
            s.if_rd   = (i < 2);
            s.if_addr = 32'h00400100;
            s.wr      = 1'b1;
            step(s, "if_drop");
        end

        for (int i = 0; i < 600; i++) begin
            s = base();
            s.rst     = ($urandom_range(0, 59) == 0);
            s.if_rd   = ($urandom_range(0, 3) != 0);
            s.if_addr = $urandom;
            s.d_rd    = ($urandom_range(0, 2) == 0);
            s.d_wr    = ($urandom_range(0, 2) == 0);
            s.d_addr  = $urandom;
            s.d_wd    = $urandom;
            s.d_be    = 4'($urandom);
            s.wr      = ($urandom_range(0, 2) != 0);
            step(s, "random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter DATA_FIRST, default 0, selects the winner of the first simultaneous request after reset: 0 = instruction port, 1 = data port.
REQ-002 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Ports if_address/if_read/if_readdata/if_waitrequest, in/in/out/out, 32/1/32/1, instruction-fetch requester (read-only).
REQ-005 Ports d_address/d_read/d_write/d_writedata/d_byteenable, all in, 32/1/1/32/4, data requester command.
REQ-006 Ports d_readdata/d_waitrequest, out/out, 32/1, data requester response.
REQ-007 Ports address/read/write/writedata/byteenable, all out, 32/1/1/32/4, shared memory bus command.
REQ-008 Ports readdata/waitrequest, in/in, 32/1, shared memory bus response.

Function
REQ-009 State machine SHALL have three states: IDLE, GRANT_IF, GRANT_D.
REQ-010 In IDLE, read, write and byteenable SHALL be 0, and address/writedata SHALL be 0.
REQ-011 In IDLE with exactly one request pending, the next state SHALL be that requester's grant state; one cycle of arbitration latency.
- Pending: if_read for the instruction port; d_read or d_write for the data port.
REQ-012 In IDLE with both requests pending, the port not granted last SHALL win (round-robin).
- last_grant is a 1-bit register updated on every grant entry.
REQ-013 In GRANT_IF, the bus SHALL carry if_address, read=if_read, write=0, byteenable=4'b1111, and writedata=0.
REQ-014 In GRANT_D, the bus SHALL carry d_address, d_read, d_write, d_writedata and d_byteenable unchanged.
REQ-015 If d_read and d_write are both 1, the bus SHALL drive write=1 and read=0.
REQ-016 The granted requester's waitrequest SHALL equal the bus waitrequest (combinational).
REQ-017 The ungranted requester's waitrequest SHALL be 1, and both requesters' waitrequest SHALL be 1 in IDLE.
REQ-018 if_readdata and d_readdata SHALL both be a combinational copy of readdata.
- Validity is qualified only by the owning port's waitrequest being low.
REQ-019 A transfer completes in a grant state on the cycle the strobe is high and waitrequest is 0.
- The grant SHALL be held, with no change of owner, until that completion.
REQ-020 On completion, if the other port is pending, the next state SHALL be that port's grant state (back-to-back, no IDLE bubble).
- Otherwise, if the same port is still pending, the grant SHALL be retained.
- Otherwise, the next state SHALL be IDLE.
REQ-021 If the granted requester drops its strobe before completion, the next state SHALL be IDLE, and no bus strobe SHALL be driven on that cycle.
REQ-022 Starvation bound: a continuously pending port SHALL be granted within one completed transfer of the other port.

Reset
REQ-023 On reset, the state SHALL be IDLE, last_grant SHALL equal DATA_FIRST inverted, and all bus command outputs SHALL be 0.
- Both requester waitrequest outputs SHALL be 1.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer: strobes go to 0 on the next edge, and no completion is signalled to the requester.

Structure
REQ-025 The state enum (IDLE/GRANT_IF/GRANT_D) and the bus width constants (ADDR_W=32, DATA_W=32, BE_W=4) SHALL live in shared package mips_bus_pkg.
REQ-026 The round-robin winner selection SHALL be one combinational sub-module, bus_rr_select (inputs: two pending flags and last_grant; outputs: grant_valid and grant_id).
REQ-027 No storage SHALL exist beyond the state register and last_grant; all data paths are combinational muxes.

Verification
REQ-028 Reset, then if_read=1 with if_address=0xBFC00000 and waitrequest=0.
- Cycle 1: IDLE. Cycle 2: read=1, address=0xBFC00000, if_waitrequest=0, if_readdata=readdata.
REQ-029 Both ports request on the same cycle with DATA_FIRST=0, and both hold.
- Instruction port granted first, data port second, then instruction port again: strict alternation.
REQ-030 Data write to 0x00001004 with byteenable=4'b0011 and writedata=0xDEADBEEF, bus waitrequest high for 3 cycles.
- Bus holds all values for 4 cycles; d_waitrequest is high for 3 cycles then low for 1; if_waitrequest is high throughout.
REQ-031 d_read=1 and d_write=1 together.
- Bus write=1, read=0.
REQ-032 Reset asserted during GRANT_D with waitrequest high.
- Next cycle: IDLE, write=0, d_waitrequest=1.
REQ-033 Instruction requester drops if_read mid-wait with no other request.
- Next cycle: IDLE, bus read=0.
